// File: rtl/switch_pkg.sv
// switch_pkg: shared constants and types for the switch control byte stream
package switch_pkg;
   localparam logic [7:0] SOF_BYTE = 8'h55;
   localparam logic [7:0] EOF_BYTE = 8'hAA;
   typedef enum logic [3:0] {IDLE, DA, SA, LEN, PAYLOAD, PARITY, EOF, HDR, DRAIN} parser_state_e;
   typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_LEN = 2'd1, ERR_PAR = 2'd2, ERR_EOF = 2'd3} err_code_e;
endpackage

// File: rtl/parser_payload_buf.sv
// parser_payload_buf: register-array payload buffer with independent write and read pointers
module parser_payload_buf #(
   parameter int BUF_DEPTH = 32
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       clear,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       rd_adv,
   output logic [7:0] rd_data
);
   localparam int AW = $clog2(BUF_DEPTH);
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [7:0] mem [BUF_DEPTH];
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
      end
   end
   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end
   assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/switch_input_parser.sv
// switch_input_parser: receives SOF/DA/SA/LEN/PAYLOAD/PARITY/EOF frames, validates them
// and forwards header then payload to the switch core over valid/ready handshakes
module switch_input_parser
   import switch_pkg::*;
#(
   parameter int MAX_LEN   = 32,
   parameter int BUF_DEPTH = 32
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] data_in,
   input  logic       sw_enable_in,
   output logic       read_out,
   output logic       hdr_valid,
   input  logic       hdr_ready,
   output logic [7:0] hdr_da,
   output logic [7:0] hdr_sa,
   output logic [7:0] hdr_length,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_last,
   output logic       err_pulse,
   output logic [1:0] err_code
);
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
   parser_state_e state;
   logic [7:0] da, sa, len, par, cnt, rd_data;
   logic [1:0] drop_code;
   logic accept, sof, drop;
   assign read_out   = state != HDR && state != DRAIN;
   assign accept     = sw_enable_in && read_out;
   assign sof        = accept && state == IDLE && data_in == SOF_BYTE;
   assign drop_code  = !accept ? ERR_NONE
                     : (state == LEN && data_in > MAX_LEN_B) ? ERR_LEN
                     : (state == PARITY && data_in != par) ? ERR_PAR
                     : (state == EOF && data_in != EOF_BYTE) ? ERR_EOF : ERR_NONE;
   assign drop       = drop_code != ERR_NONE;
   assign hdr_valid  = state == HDR;
   assign hdr_da     = da;
   assign hdr_sa     = sa;
   assign hdr_length = len;
   assign out_valid  = state == DRAIN;
   assign out_data   = out_valid ? rd_data : '0;
   assign out_last   = out_valid && cnt == len - 8'd1;
   // a fresh SOF or any drop rewinds the buffer so stale payload never leaks out
   parser_payload_buf #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (sof || drop),
      .wr_en   (accept && state == PAYLOAD),
      .wr_data (data_in),
      .rd_adv  (out_valid && out_ready),
      .rd_data (rd_data)
   );
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         da        <= '0;
         sa        <= '0;
         len       <= '0;
         par       <= '0;
         cnt       <= '0;
         err_pulse <= 1'b0;
         err_code  <= '0;
      end else begin
         err_pulse <= drop;
         err_code  <= drop_code;
         if (drop) state <= IDLE;
         else begin
            case (state)
               IDLE: if (sof) state <= DA;
               DA: if (accept) begin
                  da    <= data_in;
                  par   <= data_in;
                  state <= SA;
               end
               SA: if (accept) begin
                  sa    <= data_in;
                  par   <= par ^ data_in;
                  state <= LEN;
               end
               LEN: if (accept) begin
                  len <= data_in;
                  par <= par ^ data_in;
                  cnt <= '0;
                  if (data_in == 8'd0) state <= PARITY;
                  else state <= PAYLOAD;
               end
               PAYLOAD: if (accept) begin
                  par <= par ^ data_in;
                  cnt <= cnt + 8'd1;
                  if (cnt + 8'd1 == len) state <= PARITY;
               end
               PARITY: if (accept) state <= EOF;
               EOF: if (accept) state <= HDR;
               HDR: if (hdr_ready) begin
                  cnt <= '0;
                  if (len == 8'd0) state <= IDLE;
                  else state <= DRAIN;
               end
               DRAIN: if (out_ready) begin
                  cnt <= cnt + 8'd1;
                  if (out_last) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_switch_input_parser.sv
// tb_switch_input_parser: directed and randomized frames checked against a frame-level model
module tb_switch_input_parser;
   typedef logic [7:0] bq_t [$];
   localparam int MAX_LEN = 32;
   logic clock = 1'b0, reset_n = 1'b0, sw_enable_in = 1'b0, hdr_ready = 1'b1, out_ready = 1'b1;
   logic [7:0] data_in = '0;
   logic read_out, hdr_valid, out_valid, out_last, err_pulse;
   logic [7:0] hdr_da, hdr_sa, hdr_length, out_data;
   logic [1:0] err_code;
   int checks = 0, failures = 0, stab_bad = 0, gap_max = 0;
   bit bp_en = 1'b0, held = 1'b0;
   logic [7:0] held_data = '0;
   logic held_last = 1'b0;
   logic [31:0] obs_q [$], exp_q [$];
   bq_t fa, fc, fd, fe, ff, fg;

   switch_input_parser #(.MAX_LEN(MAX_LEN), .BUF_DEPTH(32)) dut (
      .clock(clock), .reset_n(reset_n), .data_in(data_in), .sw_enable_in(sw_enable_in),
      .read_out(read_out), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_da(hdr_da),
      .hdr_sa(hdr_sa), .hdr_length(hdr_length), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .err_pulse(err_pulse), .err_code(err_code)
   );

   always #5 clock = ~clock;

   // event log: 1=header, 2=payload byte, 3=drop
   always @(negedge clock) begin
      if (hdr_valid && hdr_ready) obs_q.push_back({2'd1, 6'd0, hdr_da, hdr_sa, hdr_length});
      if (out_valid && out_ready) obs_q.push_back({2'd2, 21'd0, out_last, out_data});
      if (err_pulse) obs_q.push_back({2'd3, 28'd0, err_code});
      if (held && (!out_valid || out_data !== held_data || out_last !== held_last)) stab_bad++;
      held      = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
   end

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      if (bp_en) begin
         hdr_ready = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         sw_enable_in = 1'b0;
         data_in = 8'($urandom);
         tick();
      end
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      gap($urandom_range(0, gap_max));
      sw_enable_in = 1'b1;
      data_in = b;
      while (!read_out && n < 2000) begin
         tick();
         n++;
      end
      if (!read_out) begin
         chk("send_timeout", 32'(read_out), 32'd1);
         sw_enable_in = 1'b0;
         return;
      end
      tick();
      sw_enable_in = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!read_out && n < 2000) begin
         tick();
         n++;
      end
      chk("idle_timeout", 32'(read_out), 32'd1);
      tick();
      tick();
   endtask

   // whole-frame reference: length limit, XOR parity over DA..payload, EOF marker
   function automatic void model(input bq_t f);
      int n = int'(f[3]);
      logic [7:0] p = 8'h00;
      if (n > MAX_LEN) begin
         exp_q.push_back({2'd3, 28'd0, 2'd1});
         return;
      end
      for (int i = 1; i <= 3 + n; i++) p ^= f[i];
      if (f[4+n] !== p) exp_q.push_back({2'd3, 28'd0, 2'd2});
      else if (f[5+n] !== 8'hAA) exp_q.push_back({2'd3, 28'd0, 2'd3});
      else begin
         exp_q.push_back({2'd1, 6'd0, f[1], f[2], f[3]});
         for (int i = 0; i < n; i++) exp_q.push_back({2'd2, 21'd0, (i == n - 1), f[4+i]});
      end
   endfunction

   // kind: 0 good, 1 bad parity, 2 bad EOF, 3 oversize LENGTH followed by non-SOF junk
   function automatic bq_t make_frame(input int kind, input int n);
      bq_t f;
      logic [7:0] p;
      f.push_back(8'h55);
      f.push_back(8'($urandom));
      f.push_back(8'($urandom));
      f.push_back(8'(n));
      p = f[1] ^ f[2] ^ f[3];
      if (kind == 3) begin
         repeat ($urandom_range(1, 4)) f.push_back(8'($urandom_range(0, 8'h54)));
         return f;
      end
      for (int i = 0; i < n; i++) begin
         f.push_back(8'($urandom));
         p ^= f[4+i];
      end
      f.push_back(kind == 1 ? p ^ (8'd1 << $urandom_range(0, 7)) : p);
      f.push_back(kind == 2 ? 8'($urandom_range(0, 8'hA9)) : 8'hAA);
      return f;
   endfunction

   initial begin
      repeat (3) @(posedge clock);
      #1;
      chk("rst_read_out", 32'(read_out), 32'd1);
      chk("rst_hdr_valid", 32'(hdr_valid), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_err", {err_pulse, err_code}, 32'd0);
      chk("rst_hdr", {hdr_da, hdr_sa, hdr_length}, 32'd0);
      chk("rst_out", {out_last, out_data}, 32'd0);
      reset_n = 1'b1;
      tick();

      fa = '{8'h55, 8'h03, 8'h07, 8'h02, 8'h11, 8'h22, 8'h35, 8'hAA};
      model(fa);
      foreach (fa[i]) send(fa[i]);
      chk("a_hdr_valid", 32'(hdr_valid), 32'd1);
      chk("a_hdr", {hdr_da, hdr_sa, hdr_length}, 32'h030702);
      chk("a_read_out_hdr", 32'(read_out), 32'd0);
      tick();
      chk("a_byte0", {out_valid, out_last, out_data}, {22'd0, 1'b1, 1'b0, 8'h11});
      tick();
      chk("a_byte1", {out_valid, out_last, out_data}, {22'd0, 1'b1, 1'b1, 8'h22});
      tick();
      chk("a_read_out_idle", 32'(read_out), 32'd1);
      wait_idle();

      model(fa);
      for (int i = 0; i < 3; i++) send(fa[i]);
      gap(3);
      for (int i = 3; i < fa.size(); i++) send(fa[i]);
      chk("b_hdr", {hdr_valid, hdr_da, hdr_sa, hdr_length}, {7'd0, 1'b1, 24'h030702});
      wait_idle();

      fc = '{8'h55, 8'h03, 8'h07, 8'h02, 8'h11, 8'h22, 8'h36, 8'hAA};
      model(fc);
      for (int i = 0; i < 7; i++) send(fc[i]);
      chk("c_err", {err_pulse, err_code}, {29'd0, 1'b1, 2'd2});
      chk("c_no_hdr", 32'(hdr_valid), 32'd0);
      send(fc[7]);
      chk("c_no_hdr_after", 32'(hdr_valid), 32'd0);
      model(fa);
      foreach (fa[i]) send(fa[i]);
      wait_idle();

      fd = '{8'h55, 8'h03, 8'h07, 8'h21, 8'h01, 8'h02, 8'hAA, 8'h37};
      model(fd);
      for (int i = 0; i < 4; i++) send(fd[i]);
      chk("d_err", {err_pulse, err_code}, {29'd0, 1'b1, 2'd1});
      tick();
      chk("d_err_one_cycle", 32'(err_pulse), 32'd0);
      for (int i = 4; i < fd.size(); i++) send(fd[i]);
      wait_idle();

      fe = '{8'h55, 8'h03, 8'h07, 8'h00, 8'h04, 8'hAA};
      model(fe);
      foreach (fe[i]) send(fe[i]);
      chk("e_hdr", {hdr_valid, hdr_length}, {23'd0, 1'b1, 8'h00});
      tick();
      chk("e_no_payload", {out_valid, read_out}, 32'd1);
      wait_idle();

      ff = make_frame(0, 6);
      model(ff);
      foreach (ff[i]) send(ff[i]);
      tick();
      tick();
      tick();
      out_ready = 1'b0;
      sw_enable_in = 1'b1;
      data_in = 8'h55;
      repeat (5) begin
         tick();
         chk("f_stall_data", {out_valid, out_last, out_data}, {22'd0, 1'b1, 1'b0, ff[6]});
         chk("f_stall_read_out", 32'(read_out), 32'd0);
      end
      out_ready = 1'b1;
      model(fa);
      send(8'h55);
      for (int i = 1; i < fa.size(); i++) send(fa[i]);
      wait_idle();

      fg = '{8'h55, 8'h03, 8'h07, 8'h04, 8'hAB, 8'hCD};
      foreach (fg[i]) send(fg[i]);
      reset_n = 1'b0;
      #2;
      chk("g_rst_read_out", 32'(read_out), 32'd1);
      chk("g_rst_outs", {hdr_valid, out_valid, err_pulse, hdr_da}, 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      model(fa);
      foreach (fa[i]) send(fa[i]);
      wait_idle();

      bp_en = 1'b1;
      gap_max = 2;
      for (int k = 0; k < 60; k++) begin
         automatic int r = $urandom_range(0, 5);
         automatic int kind = r > 3 ? 0 : r;
         automatic int n = kind == 3 ? $urandom_range(MAX_LEN + 1, 255)
                         : (k % 10 == 0) ? MAX_LEN : (k % 10 == 1) ? 0 : $urandom_range(0, MAX_LEN);
         automatic bq_t f = make_frame(kind, n);
         model(f);
         foreach (f[i]) send(f[i]);
         wait_idle();
      end
      bp_en = 1'b0;
      hdr_ready = 1'b1;
      out_ready = 1'b1;
      repeat (3) tick();

      chk("event_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) chk($sformatf("event%0d", i), obs_q[i], exp_q[i]);
      chk("stall_stability", stab_bad, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
